// File: rtl/carry_skip_adder_pkg.sv
// Shared helpers for the carry-skip adder: parameter legality check used at elaboration.
package carry_skip_adder_pkg;

  function automatic bit csa_cfg_ok(input int width, input int block);
    return (width >= 1) && (block >= 1) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: ripple-carry adder over BLOCK bits whose carry-out is
// bypassed straight from the block carry-in when every bit propagates.
module csa_skip_block #(
  parameter int BLOCK = 2
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);

  logic [BLOCK-1:0] w_p;
  logic [BLOCK-1:0] w_g;
  logic [BLOCK:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < BLOCK; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum = w_p ^ w_c[BLOCK-1:0];

  // Full propagate means the ripple result equals i_cin anyway; the mux just shortens the path.
  assign o_cout = (&w_p) ? i_cin : w_c[BLOCK];

endmodule

// File: rtl/carry_skip_adder.sv
// Registered carry-skip adder: {cout, s} = a + b + cin, captured every rising clk edge.
// No handshake: inputs are sampled every cycle and results appear one cycle later.
module carry_skip_adder
  import carry_skip_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NBLK = WIDTH / BLOCK;

  if (!csa_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("carry_skip_adder: WIDTH must be >= 1 and a multiple of BLOCK");
  end

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  // Each block gets its own carry nets so the inter-block chain stays a plain wire path.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic w_bcin;
    logic w_bcout;

    if (k == 0) begin : g_first
      assign w_bcin = cin;
    end else begin : g_next
      assign w_bcin = g_blk[k-1].w_bcout;
    end

    csa_skip_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .i_a    (a[k*BLOCK +: BLOCK]),
      .i_b    (b[k*BLOCK +: BLOCK]),
      .i_cin  (w_bcin),
      .o_sum  (w_sum[k*BLOCK +: BLOCK]),
      .o_cout (w_bcout)
    );
  end

  assign w_cout = g_blk[NBLK-1].w_bcout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_carry_skip_adder.sv
// Directed and exhaustive checks of the registered carry-skip adder at several block sizes.
module tb_carry_skip_adder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [3:0]  s_b1, s_b2, s_b4;
  logic        co_b1, co_b2, co_b4;
  logic [15:0] a16, b16, s16;
  logic        cin16, co16;

  int n_checks;
  int n_fail;

  carry_skip_adder #(.WIDTH(4), .BLOCK(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .s(s_b2), .cout(co_b2)
  );

  carry_skip_adder #(.WIDTH(4), .BLOCK(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .s(s_b1), .cout(co_b1)
  );

  carry_skip_adder #(.WIDTH(4), .BLOCK(4)) dut_b4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .s(s_b4), .cout(co_b4)
  );

  carry_skip_adder #(.WIDTH(16), .BLOCK(4)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(co16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({co_b2, s_b2} !== 5'b0_0000) begin
        n_fail++;
        $display("FAIL reset_hold: got %b/%b expected 0000/0", s_b2, co_b2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({co_b2, s_b2} !== 5'b1_1110) begin
      n_fail++;
      $display("FAIL reset_release: got %b/%b expected 1110/1", s_b2, co_b2);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ta [7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b1011, 4'b0111, 4'b0100};
    logic [3:0] tb [7] = '{4'b0100, 4'b0101, 4'b0001, 4'b0100, 4'b1000, 4'b1011, 4'b1010};
    logic [4:0] te [7] = '{5'b0_0111, 5'b0_1000, 5'b0_0100, 5'b0_0110,
                          5'b1_0011, 5'b1_0010, 5'b0_1110};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a4 = ta[i]; b4 = tb[i]; cin4 = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({co_b2, s_b2} !== te[i]) begin
        n_fail++;
        $display("FAIL basic_%0d: got cout,s=%b expected %b", i, {co_b2, s_b2}, te[i]);
      end
    end
  endtask

  task automatic test_skip_and_wrap();
    logic [3:0] ta [5] = '{4'b1001, 4'b1001, 4'b0101, 4'b1111, 4'b0000};
    logic [3:0] tb [5] = '{4'b0110, 4'b0110, 4'b1010, 4'b1111, 4'b0000};
    logic       tc [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] te [5] = '{5'b0_1111, 5'b1_0000, 5'b1_0000, 5'b1_1111, 5'b0_0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
      @(posedge clk); #1;
      n_checks++;
      if ({co_b2, s_b2} !== te[i]) begin
        n_fail++;
        $display("FAIL skip_wrap_%0d: got cout,s=%b expected %b", i, {co_b2, s_b2}, te[i]);
      end
      n_checks++;
      if ({co_b1, s_b1} !== te[i] || {co_b4, s_b4} !== te[i]) begin
        n_fail++;
        $display("FAIL skip_wrap_blk_%0d: got b1=%b b4=%b expected %b",
                 i, {co_b1, s_b1}, {co_b4, s_b4}, te[i]);
      end
    end
  endtask

  task automatic test_exhaustive4();
    logic [4:0] exp;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
          exp = 5'(ai + bi + ci);
          @(posedge clk); #1;
          n_checks++;
          if ({co_b1, s_b1} !== exp) begin
            n_fail++;
            $display("FAIL exh_blk1 a=%0d b=%0d c=%0d: got %b expected %b", ai, bi, ci, {co_b1, s_b1}, exp);
          end
          n_checks++;
          if ({co_b2, s_b2} !== exp) begin
            n_fail++;
            $display("FAIL exh_blk2 a=%0d b=%0d c=%0d: got %b expected %b", ai, bi, ci, {co_b2, s_b2}, exp);
          end
          n_checks++;
          if ({co_b4, s_b4} !== exp) begin
            n_fail++;
            $display("FAIL exh_blk4 a=%0d b=%0d c=%0d: got %b expected %b", ai, bi, ci, {co_b4, s_b4}, exp);
          end
        end
      end
    end
  endtask

  task automatic test_wide_random();
    logic [16:0] exp;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a16 = 16'($urandom_range(0, 65535));
      if (i % 10 == 0) b16 = ~a16;
      else             b16 = 16'($urandom_range(0, 65535));
      cin16 = 1'($urandom_range(0, 1));
      exp = {1'b0, a16} + {1'b0, b16} + {16'b0, cin16};
      @(posedge clk); #1;
      n_checks++;
      if ({co16, s16} !== exp) begin
        n_fail++;
        $display("FAIL wide_%0d a=%h b=%h c=%b: got %h expected %h", i, a16, b16, cin16, {co16, s16}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({co_b2, s_b2} !== 5'b0_0111) begin
      n_fail++;
      $display("FAIL arst_pre: got cout,s=%b expected 00111", {co_b2, s_b2});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({co_b2, s_b2} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL arst_immediate: got cout,s=%b expected 00000", {co_b2, s_b2});
    end
    a4 = 4'b1011; b4 = 4'b1000; cin4 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({co_b2, s_b2} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL arst_hold: got cout,s=%b expected 00000", {co_b2, s_b2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({co_b2, s_b2} !== 5'b1_0011) begin
      n_fail++;
      $display("FAIL arst_resume: got cout,s=%b expected 10011", {co_b2, s_b2});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_skip_and_wrap();
    test_exhaustive4();
    test_wide_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/carry_skip_adder.md
Name: carry_skip_adder

Overview:
- Registered N-bit carry-skip adder: {cout, s} = a + b + cin, unsigned.
- Operand word is split into fixed-size ripple-carry blocks; each block's carry-out is bypassed by a skip mux when every bit in the block propagates.
- One output register stage, so the block drops into the clocked datapath as a single-cycle arithmetic unit.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be >= 1.
- BLOCK, 2, bits per skip block; WIDTH % BLOCK must be 0 (elaboration-time error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- cin  input  1  carry into bit 0.
- s  output  WIDTH  registered sum bits.
- cout  output  1  registered carry out of the MSB.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low clears s to 0 and cout to 0 immediately, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - Deassertion is synchronised externally; the first capture happens on the first rising clk edge with rst_n high.
- Latency:
  - Inputs are sampled on each rising clk edge.
  - {cout, s} reflect those inputs after that edge: 1-cycle latency, throughput one add per cycle.
  - No enable and no handshake; the registers load every cycle.
- Combinational core, per bit i:
  - p_i = a_i ^ b_i, g_i = a_i & b_i.
  - Full-adder ripple inside each block: s_i = p_i ^ c_i, c_{i+1} = g_i | (p_i & c_i).
- Skip logic, per block k (bits k*BLOCK .. k*BLOCK+BLOCK-1):
  - P_k = AND of the block's p_i.
  - Block carry-out = P_k ? block carry-in : block ripple carry-out.
  - Block 0 carry-in = cin; block k carry-in = block k-1 carry-out; cout = last block carry-out.
- Arithmetic:
  - Result must equal the (WIDTH+1)-bit sum a + b + cin for all inputs; no saturation, no overflow flag.
  - Wrap-around: all-ones + all-ones + cin yields s = all-ones minus 1 + cin, cout = 1.
- Boundary cases:
  - All bits propagate (e.g. a = ~b): the carry bypasses every block. cin=0 gives s = all-ones, cout = 0; cin=1 gives s = 0, cout = 1.
  - X/Z on inputs is not required to be handled.
  - Reset asserted mid-stream discards the in-flight result; outputs return to 0.

Decomposition:
- No shared-package content required; WIDTH/BLOCK stay module parameters.
- The number of blocks (WIDTH/BLOCK) is a localparam in the top module.
- One natural sub-module: csa_skip_block, parameterised by BLOCK.
  - Inputs: a/b slices and cin.
  - Outputs: sum slice and skipped carry-out.
  - Instantiated WIDTH/BLOCK times via generate.
- The top module carries only the carry chain between blocks and the output register.

Test Plan:
- Reset: drive a=4'b1111, b=4'b1111, hold rst_n low across edges -> s=0, cout=0. Release -> next edge gives s=4'b1110, cout=1.
- Basic adds, cin=0, one result per cycle, 1-cycle latency:
  - 0011+0100 -> 0111/0
  - 0011+0101 -> 1000/0
  - 0011+0001 -> 0100/0
  - 0010+0100 -> 0110/0
  - 1011+1000 -> 0011/1
  - 0111+1011 -> 0010/1
  - 0100+1010 -> 1110/0
- Full-propagate skip path:
  - 1001+0110, cin=0 -> 1111/0.
  - Same with cin=1 -> 0000/1.
  - 0101+1010, cin=1 -> 0000/1.
- Max wrap: 1111+1111, cin=1 -> 1111/1; 0000+0000, cin=0 -> 0000/0.
- Exhaustive, WIDTH=4 and BLOCK in {1,2,4}: all 512 (a,b,cin) combinations, compare against a reference a+b+cin one cycle later. Repeat randomized for WIDTH=16, BLOCK=4.
- Asynchronous reset pulse between clock edges mid-sequence -> outputs drop to 0 without waiting for clk; normal results resume one edge after release.
